// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters.
// In-order responses are steered back through a small ID FIFO.
module mem_port_arbiter #(
  parameter int MEM_W   = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m0_req_i,
  output logic                         m0_gnt_o,
  input  logic [31:0]                  m0_addr_i,
  input  logic                         m0_we_i,
  input  logic [MEM_W/8-1:0]           m0_be_i,
  input  logic [MEM_W-1:0]             m0_wdata_i,
  output logic                         m0_rvalid_o,
  output logic                         m0_err_o,
  output logic [MEM_W-1:0]             m0_rdata_o,
  input  logic                         m1_req_i,
  output logic                         m1_gnt_o,
  input  logic [31:0]                  m1_addr_i,
  input  logic                         m1_we_i,
  input  logic [MEM_W/8-1:0]           m1_be_i,
  input  logic [MEM_W-1:0]             m1_wdata_i,
  output logic                         m1_rvalid_o,
  output logic                         m1_err_o,
  output logic [MEM_W-1:0]             m1_rdata_o,
  output logic                         s_req_o,
  input  logic                         s_gnt_i,
  output logic [31:0]                  s_addr_o,
  output logic                         s_we_o,
  output logic [MEM_W/8-1:0]           s_be_o,
  output logic [MEM_W-1:0]             s_wdata_o,
  input  logic                         s_rvalid_i,
  input  logic                         s_err_i,
  input  logic [MEM_W-1:0]             s_rdata_i,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o,
  output logic                         spurious_rsp_o
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      wp_q, wp_d;
  logic [PW-1:0]      rp_q, rp_d;
  logic [MAX_OUT-1:0] id_q, id_d;
  logic               prio_q, prio_d;
  logic               lock_q, lock_d;
  logic               lid_q, lid_d;
  logic               spur_q, spur_d;

  logic sel, full, has, s_req, xfer, pop, head;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // A locked selection wins over round-robin until its transfer lands.
  always_comb begin
    if (lock_q)
      sel = lid_q;
    else if (m0_req_i & m1_req_i)
      sel = prio_q;
    else
      sel = m1_req_i;
  end

  assign full  = (cnt_q == CW'(MAX_OUT));
  assign has   = (cnt_q != '0);
  assign s_req = rst & (m0_req_i | m1_req_i) & ~full;
  assign xfer  = s_req & s_gnt_i;
  assign pop   = s_rvalid_i & has;
  assign head  = id_q[rp_q];

  always_comb begin
    cnt_d  = cnt_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    id_d   = id_q;
    prio_d = prio_q;
    lock_d = lock_q;
    lid_d  = lid_q;
    spur_d = spur_q;
    if (xfer) begin
      id_d[wp_q] = sel;
      wp_d       = inc(wp_q);
      prio_d     = ~sel;
      lock_d     = 1'b0;
    end else if (s_req) begin
      lock_d = 1'b1;
      lid_d  = sel;
    end
    if (pop)
      rp_d = inc(rp_q);
    if (xfer & ~pop)
      cnt_d = cnt_q + 1'b1;
    else if (pop & ~xfer)
      cnt_d = cnt_q - 1'b1;
    if (s_rvalid_i & ~has)
      spur_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      id_q   <= '0;
      prio_q <= 1'b0;
      lock_q <= 1'b0;
      lid_q  <= 1'b0;
      spur_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      id_q   <= id_d;
      prio_q <= prio_d;
      lock_q <= lock_d;
      lid_q  <= lid_d;
      spur_q <= spur_d;
    end
  end

  assign s_req_o   = s_req;
  assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = sel ? m1_we_i    : m0_we_i;
  assign s_be_o    = sel ? m1_be_i    : m0_be_i;
  assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
  assign m0_gnt_o  = xfer & ~sel;
  assign m1_gnt_o  = xfer & sel;

  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop & head;
  assign m0_err_o    = m0_rvalid_o & s_err_i;
  assign m1_err_o    = m1_rvalid_o & s_err_i;
  assign m0_rdata_o  = {MEM_W{m0_rvalid_o}} & s_rdata_i;
  assign m1_rdata_o  = {MEM_W{m1_rvalid_o}} & s_rdata_i;

  assign outstanding_o  = cnt_q;
  assign spurious_rsp_o = spur_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: queue-based model checked every cycle,
// plus directed vectors with literal expectations.
module tb_mem_port_arbiter;

  localparam int MEM_W   = 32;
  localparam int MAX_OUT = 2;

  logic        clk = 0;
  logic        rst = 0;
  logic        m0_req, m1_req, m0_gnt, m1_gnt;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_we, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wd, m1_wd;
  logic        m0_rv, m1_rv, m0_err, m1_err;
  logic [31:0] m0_rd, m1_rd;
  logic        s_req, s_gnt, s_we;
  logic [31:0] s_addr, s_wd;
  logic [3:0]  s_be;
  logic        s_rv, s_err;
  logic [31:0] s_rd;
  logic [1:0]  outst;
  logic        spur;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.MEM_W(MEM_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt),
    .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wd),
    .m0_rvalid_o(m0_rv), .m0_err_o(m0_err),
    .m0_rdata_o(m0_rd),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt),
    .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wd),
    .m1_rvalid_o(m1_rv), .m1_err_o(m1_err),
    .m1_rdata_o(m1_rd),
    .s_req_o(s_req), .s_gnt_i(s_gnt),
    .s_addr_o(s_addr), .s_we_o(s_we),
    .s_be_o(s_be), .s_wdata_o(s_wd),
    .s_rvalid_i(s_rv), .s_err_i(s_err),
    .s_rdata_i(s_rd),
    .outstanding_o(outst),
    .spurious_rsp_o(spur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Model: in-flight requester IDs as a queue, plus RR/lock/sticky flags.
  int q[$];
  bit m_prio, m_lock, m_lid, m_spur;
  bit e_sreq, e_sel, e_g0, e_g1, e_rv0, e_rv1;
  bit e_er0, e_er1;
  logic [31:0] e_rd0, e_rd1;

  function automatic void calc();
    bit any, both, h;
    any    = m0_req | m1_req;
    both   = m0_req & m1_req;
    e_sreq = rst && any && (q.size() < MAX_OUT);
    if (m_lock)    e_sel = m_lid;
    else if (both) e_sel = m_prio;
    else           e_sel = m1_req;
    e_g0  = e_sreq && s_gnt && !e_sel;
    e_g1  = e_sreq && s_gnt && e_sel;
    h     = (q.size() > 0) ? q[0][0] : 1'b0;
    e_rv0 = s_rv && q.size() > 0 && !h;
    e_rv1 = s_rv && q.size() > 0 && h;
    e_er0 = e_rv0 && s_err;
    e_er1 = e_rv1 && s_err;
    e_rd0 = e_rv0 ? s_rd : 32'h0;
    e_rd1 = e_rv1 ? s_rd : 32'h0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_prio = 0;
      m_lock = 0;
      m_lid  = 0;
      m_spur = 0;
    end else begin
      calc();
      if (s_rv) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_spur = 1;
      end
      if (e_sreq && s_gnt) begin
        q.push_back(int'(e_sel));
        m_prio = !e_sel;
        m_lock = 0;
      end else if (e_sreq) begin
        m_lock = 1;
        m_lid  = e_sel;
      end
    end
  end

  always @(negedge clk) begin
    calc();
    chk("s_req", 32'(s_req), 32'(e_sreq));
    chk("m0_gnt", 32'(m0_gnt), 32'(e_g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(e_g1));
    chk("m0_rvalid", 32'(m0_rv), 32'(e_rv0));
    chk("m1_rvalid", 32'(m1_rv), 32'(e_rv1));
    chk("m0_err", 32'(m0_err), 32'(e_er0));
    chk("m1_err", 32'(m1_err), 32'(e_er1));
    chk("m0_rdata", m0_rd, e_rd0);
    chk("m1_rdata", m1_rd, e_rd1);
    chk("outstanding", 32'(outst), 32'(q.size()));
    chk("spurious", 32'(spur), 32'(m_spur));
    if (e_sreq) begin
      chk("s_addr", s_addr, e_sel ? m1_addr : m0_addr);
      chk("s_we", 32'(s_we), 32'(e_sel ? m1_we : m0_we));
      chk("s_be", 32'(s_be), 32'(e_sel ? m1_be : m0_be));
      chk("s_wdata", s_wd, e_sel ? m1_wd : m0_wd);
    end
  end

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {m0_req, m1_req, m0_we, m1_we, s_gnt, s_rv, s_err} = '0;
    m0_addr = 0; m1_addr = 0; m0_be = 4'hF; m1_be = 4'hF;
    m0_wd = 32'h1111_0000; m1_wd = 32'h2222_0000; s_rd = 0;
    nx();
    #3;
    chk("rst_outst", 32'(outst), 0);
    chk("rst_sreq", 32'(s_req), 0);
    nx();
    rst = 1;
    #3;
    chk("rst_spur", 32'(spur), 0);
    nx();

    // single requester read
    m1_req = 1; m1_addr = 32'h100; s_gnt = 1;
    #3;
    chk("t1_gnt1", 32'(m1_gnt), 1);
    chk("t1_gnt0", 32'(m0_gnt), 0);
    chk("t1_addr", s_addr, 32'h100);
    chk("t1_out0", 32'(outst), 0);
    nx();
    m1_req = 0; s_gnt = 0; s_rv = 1; s_rd = 32'hDEADBEEF;
    #3;
    chk("t1_rv1", 32'(m1_rv), 1);
    chk("t1_rd1", m1_rd, 32'hDEADBEEF);
    chk("t1_rv0", 32'(m0_rv), 0);
    chk("t1_out1", 32'(outst), 1);
    nx();
    s_rv = 0;
    #3;
    chk("t1_out2", 32'(outst), 0);
    nx();

    // contention: grants alternate, responses follow in order
    m0_req = 1; m1_req = 1; s_gnt = 1;
    m0_addr = 32'h200; m1_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      s_rv = (i > 0);
      s_rd = 32'hA0 + i;
      #3;
      chk("t2_gnt0", 32'(m0_gnt), 32'(i % 2 == 0));
      chk("t2_gnt1", 32'(m1_gnt), 32'(i % 2 == 1));
      if (i > 0) begin
        chk("t2_rv0", 32'(m0_rv), 32'((i - 1) % 2 == 0));
        chk("t2_rv1", 32'(m1_rv), 32'((i - 1) % 2 == 1));
      end
      nx();
    end
    m0_req = 0; m1_req = 0; s_gnt = 0; s_rv = 1;
    #3;
    chk("t2_drain", 32'(m1_rv), 1);
    nx();
    s_rv = 0;

    // lock holds m1 while m0 joins
    m1_req = 1; m1_addr = 32'h400; m0_addr = 32'h500;
    for (int i = 0; i < 3; i++) begin
      m0_req = (i > 0);
      #3;
      chk("t3_addr", s_addr, 32'h400);
      chk("t3_nog", 32'(m0_gnt | m1_gnt), 0);
      nx();
    end
    s_gnt = 1;
    #3;
    chk("t3_g1", 32'(m1_gnt), 1);
    chk("t3_addr2", s_addr, 32'h400);
    nx();
    m1_req = 0;
    #3;
    chk("t3_g0", 32'(m0_gnt), 1);
    chk("t3_addr3", s_addr, 32'h500);
    nx();

    // full: count==2 blocks requests even with a pop
    m1_req = 1;
    #3;
    chk("t4_sreq0", 32'(s_req), 0);
    chk("t4_out2", 32'(outst), 2);
    nx();
    s_rv = 1;
    #3;
    chk("t4_sreq1", 32'(s_req), 0);
    chk("t4_rv1", 32'(m1_rv), 1);
    nx();
    #3;
    chk("t4_sreq2", 32'(s_req), 1);
    chk("t4_g1", 32'(m1_gnt), 1);
    chk("t4_rv0", 32'(m0_rv), 1);
    nx();
    m0_req = 0; m1_req = 0;
    #3;
    chk("t4_out1", 32'(outst), 1);
    nx();
    s_rv = 0;
    nx();

    // error response, then spurious
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wd = 32'h1234;
    #3;
    chk("t5_we", 32'(s_we), 1);
    chk("t5_wd", s_wd, 32'h1234);
    nx();
    m0_req = 0; s_gnt = 0; s_rv = 1; s_err = 1;
    #3;
    chk("t5_rv0", 32'(m0_rv), 1);
    chk("t5_err0", 32'(m0_err), 1);
    chk("t5_err1", 32'(m1_err), 0);
    nx();
    s_err = 0;
    #3;
    chk("t5_sp_rv", 32'(m0_rv | m1_rv), 0);
    nx();
    s_rv = 0;
    #3;
    chk("t5_spur", 32'(spur), 1);
    nx();
    #3;
    chk("t5_sticky", 32'(spur), 1);

    // async reset with two in flight
    nx();
    m0_req = 1; m0_we = 0; s_gnt = 1;
    nx();
    nx();
    #3;
    chk("t6_out2", 32'(outst), 2);
    rst = 0;
    #1;
    chk("t6_out0", 32'(outst), 0);
    chk("t6_sreq", 32'(s_req), 0);
    chk("t6_gnt", 32'(m0_gnt), 0);
    chk("t6_spur", 32'(spur), 0);
    nx();
    m0_req = 0; s_gnt = 0;
    rst = 1;
    s_rv = 1;
    #3;
    chk("t6_norv", 32'(m0_rv | m1_rv), 0);
    nx();
    s_rv = 0;
    #3;
    chk("t6_spur2", 32'(spur), 1);
    nx();
    nx();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
